// File: rtl/upc_pkg.sv
// Shared definitions for the UPC checkout-lane controller.
//   state_t : controller states (IDLE, SCAN, ALARM, DONE)
//   *_BIT   : field positions of the {u,p,c,m} item code
package upc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ALARM = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned U_BIT = 3;
  localparam int unsigned P_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned M_BIT = 0;

endpackage

// File: rtl/upc_item_decode.sv
// Combinational decode of a 4-bit UPC item code into its discount and
// stolen flags.
// Ports:
//   code  in  4  item code {u,p,c,m}
//   dscnt out 1  item carries a discount
//   stln  out 1  item is flagged as stolen
module upc_item_decode
  import upc_pkg::*;
(
  input  logic [3:0] code,
  output logic       dscnt,
  output logic       stln
);

  logic u, p, c, m;

  assign u = code[U_BIT];
  assign p = code[P_BIT];
  assign c = code[C_BIT];
  assign m = code[M_BIT];

  assign dscnt = p | (u & c);
  assign stln  = ~(p | (~u & c) | m);

endmodule

// File: rtl/upc_checkout_ctrl.sv
// Checkout-lane controller: frames a sale (start -> items -> end), accepts
// item codes over a valid/ready handshake, keeps saturating per-sale item,
// discount and stolen counts, and optionally stalls on a stolen item.
//
// Configuration macro: UPC_ALARM_EN
//   defined   : an accepted stolen item moves SCAN -> ALARM until alarm_clear
//   undefined : ALARM is unreachable, alarm is tied low, scanning never stalls
//
// Handshake: an item is transferred on a rising clk edge where
// item_valid && item_ready. item_ready depends only on the registered state,
// so the producer may hold item_valid/item_code until it sees ready.
//
// Ports:
//   clk, reset              clock (rising) and async active-high reset
//   start_sale              open a sale (IDLE only)
//   end_sale                close the sale (SCAN only)
//   item_valid, item_code   offered item
//   item_ready              item accepted this cycle when valid
//   alarm_clear             attendant acknowledge (ALARM only)
//   busy, alarm, sale_done  state decodes; sale_done is a one-cycle pulse
//   item_count, dscnt_count, stln_count   per-sale saturating counters
module upc_checkout_ctrl
  import upc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_sale,
  input  logic             end_sale,
  input  logic             item_valid,
  input  logic [3:0]       item_code,
  output logic             item_ready,
  input  logic             alarm_clear,
  output logic             busy,
  output logic             alarm,
  output logic             sale_done,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] dscnt_count,
  output logic [CNT_W-1:0] stln_count
);

`ifdef UPC_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_next;
  logic   dscnt, stln;
  logic   accept;

  upc_item_decode u_decode (
    .code  (item_code),
    .dscnt (dscnt),
    .stln  (stln)
  );

  assign item_ready = (state == SCAN);
  assign busy       = (state != IDLE);
  assign sale_done  = (state == DONE);
  assign accept     = item_valid & item_ready;

`ifdef UPC_ALARM_EN
  assign alarm = (state == ALARM);
`else
  assign alarm = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A stolen item outranks end_sale in the same cycle; the end request is
  // dropped and the host must re-issue it after the alarm is cleared.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_sale) state_next = SCAN;
      SCAN: begin
        if (accept && stln && ALARM_EN) state_next = ALARM;
        else if (end_sale)              state_next = DONE;
      end
      ALARM:   if (alarm_clear) state_next = SCAN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters are cleared only by a new sale so the host can read them after
  // sale_done while the controller sits in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      item_count  <= '0;
      dscnt_count <= '0;
      stln_count  <= '0;
    end else if (state == IDLE && start_sale) begin
      item_count  <= '0;
      dscnt_count <= '0;
      stln_count  <= '0;
    end else if (accept) begin
      if (item_count != CNT_MAX)           item_count  <= item_count + 1'b1;
      if (dscnt && dscnt_count != CNT_MAX) dscnt_count <= dscnt_count + 1'b1;
      if (stln && stln_count != CNT_MAX)   stln_count  <= stln_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Self-checking bench for upc_checkout_ctrl (CNT_W = 8). Follows whichever
// UPC_ALARM_EN setting the design is built with.
module tb_upc_checkout_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef UPC_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_sale = 1'b0;
  logic             end_sale = 1'b0;
  logic             item_valid = 1'b0;
  logic [3:0]       item_code = '0;
  logic             item_ready;
  logic             alarm_clear = 1'b0;
  logic             busy;
  logic             alarm;
  logic             sale_done;
  logic [CNT_W-1:0] item_count;
  logic [CNT_W-1:0] dscnt_count;
  logic [CNT_W-1:0] stln_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected {items, dscnt, stln} snapshots for the random scenario.
  logic [3*CNT_W-1:0] exp_q[$];

  upc_checkout_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_sale  (start_sale),
    .end_sale    (end_sale),
    .item_valid  (item_valid),
    .item_code   (item_code),
    .item_ready  (item_ready),
    .alarm_clear (alarm_clear),
    .busy        (busy),
    .alarm       (alarm),
    .sale_done   (sale_done),
    .item_count  (item_count),
    .dscnt_count (dscnt_count),
    .stln_count  (stln_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  function automatic bit ref_dscnt(input logic [3:0] code);
    return code[2] | (code[3] & code[1]);
  endfunction

  function automatic bit ref_stln(input logic [3:0] code);
    return !(code[2] | (!code[3] & code[1]) | code[0]);
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_sale = 1'b1;
    step();
    start_sale = 1'b0;
  endtask

  task automatic do_end();
    end_sale = 1'b1;
    step();
    end_sale = 1'b0;
  endtask

  task automatic do_clear();
    alarm_clear = 1'b1;
    step();
    alarm_clear = 1'b0;
  endtask

  task automatic do_item(input logic [3:0] code);
    item_valid = 1'b1;
    item_code  = code;
    step();
    item_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({item_ready, busy, alarm, sale_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {item_ready, busy, alarm, sale_done});
    end
    n_cmp++;
    if ({item_count, dscnt_count, stln_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", item_count, dscnt_count, stln_count);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic_sale();
    do_start();
    n_cmp++;
    if (item_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: ready=%b busy=%b expected 1/1", item_ready, busy);
    end
    item_valid = 1'b1;
    item_code = 4'b0100; step();
    item_code = 4'b1011; step();
    item_code = 4'b0001; step();
    item_valid = 1'b0;
    do_end();
    n_cmp++;
    if (sale_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_sale_done: got %b expected 1", sale_done);
    end
    n_cmp++;
    if (item_count !== 8'd3 || dscnt_count !== 8'd2 || stln_count !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_counts: got %0d/%0d/%0d expected 3/2/0", item_count, dscnt_count, stln_count);
    end
    step();
    n_cmp++;
    if (sale_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_pulse: done=%b busy=%b expected 0/0", sale_done, busy);
    end
    step();
    n_cmp++;
    if (item_count !== 8'd3 || dscnt_count !== 8'd2 || stln_count !== 8'd0) begin
      n_fail++;
      $display("FAIL counts_hold_idle: got %0d/%0d/%0d expected 3/2/0", item_count, dscnt_count, stln_count);
    end
  endtask

  task automatic test_decode_all();
    for (int code = 0; code < 16; code++) begin
      logic [3:0] c4;
      c4 = 4'(code);
      do_start();
      do_item(c4);
      n_cmp++;
      if (alarm !== (ALARM_ON & ref_stln(c4))) begin
        n_fail++;
        $display("FAIL decode_alarm[%0d]: got %b expected %b", code, alarm, ALARM_ON & ref_stln(c4));
      end
      if (alarm === 1'b1) do_clear();
      n_cmp++;
      if (item_count !== 8'd1 || dscnt_count !== 8'(ref_dscnt(c4)) || stln_count !== 8'(ref_stln(c4))) begin
        n_fail++;
        $display("FAIL decode_counts[%0d]: got %0d/%0d/%0d expected 1/%0d/%0d",
                 code, item_count, dscnt_count, stln_count, ref_dscnt(c4), ref_stln(c4));
      end
      do_end();
      step();
    end
  endtask

  task automatic test_alarm();
    do_start();
    do_item(4'b0000);
    n_cmp++;
    if (alarm !== ALARM_ON || item_ready !== !ALARM_ON || stln_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stolen_first: alarm=%b ready=%b stln=%0d expected %b/%b/1",
               alarm, item_ready, stln_count, ALARM_ON, !ALARM_ON);
    end
    if (ALARM_ON) begin
      // Hold with every non-clear input asserted; all must be ignored.
      item_valid = 1'b1; item_code = 4'b0100; end_sale = 1'b1; start_sale = 1'b1;
      repeat (5) step();
      item_valid = 1'b0; end_sale = 1'b0; start_sale = 1'b0;
      n_cmp++;
      if (alarm !== 1'b1 || item_ready !== 1'b0 || sale_done !== 1'b0 || item_count !== 8'd1) begin
        n_fail++;
        $display("FAIL alarm_hold: alarm=%b ready=%b done=%b items=%0d expected 1/0/0/1",
                 alarm, item_ready, sale_done, item_count);
      end
      do_clear();
      n_cmp++;
      if (item_ready !== 1'b1 || alarm !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_latency: ready=%b alarm=%b expected 1/0", item_ready, alarm);
      end
    end else begin
      do_item(4'b1010);
      n_cmp++;
      if (alarm !== 1'b0 || item_ready !== 1'b1 || stln_count !== 8'd2 || dscnt_count !== 8'd1) begin
        n_fail++;
        $display("FAIL no_alarm_mode: alarm=%b ready=%b stln=%0d dscnt=%0d expected 0/1/2/1",
                 alarm, item_ready, stln_count, dscnt_count);
      end
    end
    do_end();
    step();
  endtask

  task automatic test_item_with_end();
    do_start();
    item_valid = 1'b1; item_code = 4'b0010; end_sale = 1'b1;
    step();
    item_valid = 1'b0; end_sale = 1'b0;
    n_cmp++;
    if (sale_done !== 1'b1 || item_count !== 8'd1 || dscnt_count !== 8'd0 || stln_count !== 8'd0) begin
      n_fail++;
      $display("FAIL item_with_end: done=%b counts=%0d/%0d/%0d expected 1, 1/0/0",
               sale_done, item_count, dscnt_count, stln_count);
    end
    step();
    // Stolen item together with end_sale: alarm wins when enabled.
    do_start();
    item_valid = 1'b1; item_code = 4'b1000; end_sale = 1'b1;
    step();
    item_valid = 1'b0; end_sale = 1'b0;
    n_cmp++;
    if (sale_done !== !ALARM_ON || alarm !== ALARM_ON || stln_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stolen_with_end: done=%b alarm=%b stln=%0d expected %b/%b/1",
               sale_done, alarm, stln_count, !ALARM_ON, ALARM_ON);
    end
    if (ALARM_ON) begin
      do_clear();
      n_cmp++;
      if (busy !== 1'b1 || item_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL end_dropped: busy=%b ready=%b expected 1/1", busy, item_ready);
      end
      do_end();
    end
    step();
  endtask

  task automatic test_random();
    int m_items = 0, m_d = 0, m_s = 0;
    bit m_alarm = 1'b0;
    logic [3*CNT_W-1:0] got, expv;
    do_start();
    for (int cyc = 0; cyc < 300; cyc++) begin
      bit v, clr;
      logic [3:0] code;
      v    = 1'($urandom_range(0, 1));
      code = 4'($urandom_range(0, 15));
      clr  = ($urandom_range(0, 3) == 0);
      item_valid = v; item_code = code; alarm_clear = clr;
      step();
      if (m_alarm) begin
        if (clr) m_alarm = 1'b0;
      end else if (v) begin
        m_items++;
        m_d += ref_dscnt(code);
        m_s += ref_stln(code);
        if (ALARM_ON && ref_stln(code)) m_alarm = 1'b1;
      end
      exp_q.push_back({8'(sat(m_items)), 8'(sat(m_d)), 8'(sat(m_s))});
      got  = {item_count, dscnt_count, stln_count};
      expv = exp_q.pop_front();
      n_cmp++;
      if (got !== expv || alarm !== m_alarm || item_ready !== !m_alarm) begin
        n_fail++;
        $display("FAIL random[%0d]: counts=%h alarm=%b ready=%b expected %h/%b/%b",
                 cyc, got, alarm, item_ready, expv, m_alarm, !m_alarm);
      end
    end
    item_valid = 1'b0; alarm_clear = 1'b0;
    if (m_alarm) do_clear();
    do_end();
    n_cmp++;
    if (sale_done !== 1'b1) begin
      n_fail++;
      $display("FAIL random_done: got %b expected 1", sale_done);
    end
    step();
  endtask

  task automatic test_saturation();
    int n = 0;
    bit seen_max = 1'b0;
    do_start();
    for (int cyc = 0; cyc < 320; cyc++) begin
      bit v;
      v = ($urandom_range(0, 7) != 0);
      item_valid = v; item_code = 4'b0100;
      step();
      if (v) n++;
      if (sat(n) == CNT_MAX && !seen_max) begin
        seen_max = 1'b1;
        n_cmp++;
        if (item_count !== 8'(CNT_MAX) || dscnt_count !== 8'(CNT_MAX)) begin
          n_fail++;
          $display("FAIL sat_reach: got %0d/%0d expected %0d", item_count, dscnt_count, CNT_MAX);
        end
      end
    end
    item_valid = 1'b0;
    n_cmp++;
    if (item_count !== 8'(sat(n)) || dscnt_count !== 8'(sat(n)) || stln_count !== 8'd0) begin
      n_fail++;
      $display("FAIL saturation: got %0d/%0d/%0d expected %0d/%0d/0",
               item_count, dscnt_count, stln_count, sat(n), sat(n));
    end
    do_end();
    step();
  endtask

  task automatic test_reset_mid_sale();
    do_start();
    do_item(4'b0100);
    do_item(4'b0000);
    n_cmp++;
    if (item_count !== 8'd2 || alarm !== ALARM_ON) begin
      n_fail++;
      $display("FAIL pre_reset: items=%0d alarm=%b expected 2/%b", item_count, alarm, ALARM_ON);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({item_ready, busy, alarm, sale_done} !== 4'b0000 ||
        {item_count, dscnt_count, stln_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: flags=%b counts=%0d/%0d/%0d expected 0000 0/0/0",
               {item_ready, busy, alarm, sale_done}, item_count, dscnt_count, stln_count);
    end
    step();
    n_cmp++;
    if (sale_done !== 1'b0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %b expected 0", sale_done);
    end
    reset = 1'b0;
    step();
    do_start();
    n_cmp++;
    if (item_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset: ready=%b busy=%b expected 1/1", item_ready, busy);
    end
    do_item(4'b1011);
    do_end();
    n_cmp++;
    if (sale_done !== 1'b1 || item_count !== 8'd1 || dscnt_count !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_sale: done=%b items=%0d dscnt=%0d expected 1/1/1",
               sale_done, item_count, dscnt_count);
    end
    step();
  endtask

  task automatic test_stray_controls();
    // alarm_clear and end_sale in IDLE must not start anything.
    alarm_clear = 1'b1; end_sale = 1'b1;
    step();
    alarm_clear = 1'b0; end_sale = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || sale_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle: busy=%b done=%b expected 0/0", busy, sale_done);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_sale();
    test_decode_all();
    test_alarm();
    test_item_with_end();
    test_random();
    test_saturation();
    test_reset_mid_sale();
    test_stray_controls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
